des_key_schedule_seq: RTL and testbench

- Iterative DES key schedule. Expands a 64-bit key into sixteen 48-bit round subkeys at one subkey per clock.
- Sits directly upstream of feistel_network and drives its subkey_0..subkey_15 inputs.
- Holds the full subkey set in registers so the combinational network sees stable keys. keys_valid qualifies the set.
- decrypt selects reversed subkey order, so the same Feistel network performs decryption.

---
 rtl/des_key_schedule_seq.sv | 173 +++++++++++++++++
 tb/tb_des_key_schedule_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule_seq.sv
// Iterative DES key schedule: expands a 64-bit key into sixteen 48-bit round
// subkeys, one per clock, and holds the complete set in registers for a
// downstream combinational Feistel network. keys_valid qualifies the set;
// decrypt stores the subkeys in reversed order.
module des_key_schedule_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        busy,
  output logic        keys_valid,
  output logic [47:0] subkey_0,
  output logic [47:0] subkey_1,
  output logic [47:0] subkey_2,
  output logic [47:0] subkey_3,
  output logic [47:0] subkey_4,
  output logic [47:0] subkey_5,
  output logic [47:0] subkey_6,
  output logic [47:0] subkey_7,
  output logic [47:0] subkey_8,
  output logic [47:0] subkey_9,
  output logic [47:0] subkey_10,
  output logic [47:0] subkey_11,
  output logic [47:0] subkey_12,
  output logic [47:0] subkey_13,
  output logic [47:0] subkey_14,
  output logic [47:0] subkey_15
);

  // Permuted choice 1: DES bit numbers (1 = MSB of the 64-bit key).
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: DES bit numbers (1 = MSB of the 56-bit C||D).
  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TABLE[6'(i)])];
    end
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    k = '0;
    for (int i = 0; i < 48; i++) begin
      k[6'(47 - i)] = cd[6'(56 - PC2_TABLE[6'(i)])];
    end
    return k;
  endfunction

  state_t      state;
  state_t      state_next;
  logic [3:0]  round;
  logic [27:0] c_reg;
  logic [27:0] d_reg;
  logic        dec_r;
  logic [47:0] subkeys [16];

  logic        accept;
  logic        one_shift;
  logic [27:0] c_rot;
  logic [27:0] d_rot;
  logic [3:0]  slot;
  logic [47:0] round_key;
  logic [55:0] key_pc1;

  // A start is honoured only while no generation is running.
  assign accept = start && (state != GEN);

  // Round datapath: rotate C/D by this round's amount and form the subkey.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // before any branch, so no storage (latch) can be inferred.
    one_shift = (round == 4'd0) || (round == 4'd1) ||
                (round == 4'd8) || (round == 4'd15);
    c_rot     = one_shift ? {c_reg[26:0], c_reg[27]} : {c_reg[25:0], c_reg[27:26]};
    d_rot     = one_shift ? {d_reg[26:0], d_reg[27]} : {d_reg[25:0], d_reg[27:26]};
    slot      = dec_r ? ~round : round;
    round_key = pc2({c_rot, d_rot});
    key_pc1   = pc1(key_in);
  end

  // Next-state logic: IDLE/DONE wait for start, GEN runs sixteen rounds.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = GEN;
      GEN:     if (round == 4'd15) state_next = DONE;
      DONE:    if (start) state_next = GEN;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked blocks use non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Key state: load on accepted start, then one rotation and subkey per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round <= 4'd0;
      c_reg <= '0;
      d_reg <= '0;
      dec_r <= 1'b0;
      // NOTE: the subkey bank is deliberately reset so the network never sees
      // stale key material after reset; this keeps it in flops, not RAM.
      for (int i = 0; i < 16; i++) subkeys[i] <= '0;
    end else if (accept) begin
      c_reg <= key_pc1[55:28];
      d_reg <= key_pc1[27:0];
      dec_r <= decrypt;
      round <= 4'd0;
    end else if (state == GEN) begin
      c_reg         <= c_rot;
      d_reg         <= d_rot;
      subkeys[slot] <= round_key;
      round         <= round + 4'd1;
    end
  end

  assign busy       = (state == GEN);
  assign keys_valid = (state == DONE);

  assign subkey_0  = subkeys[0];
  assign subkey_1  = subkeys[1];
  assign subkey_2  = subkeys[2];
  assign subkey_3  = subkeys[3];
  assign subkey_4  = subkeys[4];
  assign subkey_5  = subkeys[5];
  assign subkey_6  = subkeys[6];
  assign subkey_7  = subkeys[7];
  assign subkey_8  = subkeys[8];
  assign subkey_9  = subkeys[9];
  assign subkey_10 = subkeys[10];
  assign subkey_11 = subkeys[11];
  assign subkey_12 = subkeys[12];
  assign subkey_13 = subkeys[13];
  assign subkey_14 = subkeys[14];
  assign subkey_15 = subkeys[15];

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Bench for des_key_schedule_seq: a transaction-level model of the schedule
// (cumulative rotations, direct DES tables) compared every cycle, directed
// scenarios with known-answer vectors, a DES round network driven by the DUT
// subkeys, and a randomized start/key/decrypt phase.
module tb_des_key_schedule_seq;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PTXT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CTXT = 64'h85E813540F0AB405;

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
    16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53,
    46,42,50,36,29,32};
  localparam int IP [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1,
    59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int E [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13,
    12,13,14,15,16,17, 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
    28,29,30,31,32,1};
  localparam int P [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,   0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,   15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,   3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,   13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,   13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,   1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,   13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,   3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,   14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,   11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,   10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,   4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,   13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,   6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,   1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,   2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key_in;
  logic        decrypt;
  logic        start;
  logic        busy;
  logic        keys_valid;
  logic [47:0] sk [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  des_key_schedule_seq dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .decrypt(decrypt), .start(start),
    .busy(busy), .keys_valid(keys_valid),
    .subkey_0(sk[0]),   .subkey_1(sk[1]),   .subkey_2(sk[2]),   .subkey_3(sk[3]),
    .subkey_4(sk[4]),   .subkey_5(sk[5]),   .subkey_6(sk[6]),   .subkey_7(sk[7]),
    .subkey_8(sk[8]),   .subkey_9(sk[9]),   .subkey_10(sk[10]), .subkey_11(sk[11]),
    .subkey_12(sk[12]), .subkey_13(sk[13]), .subkey_14(sk[14]), .subkey_15(sk[15])
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // DES key schedule straight from the definition: K(n) = PC-2 of C0/D0
  // rotated by the cumulative shift of rounds 1..n.
  function automatic logic [47:0] model_subkey(input logic [63:0] key, input int n);
    logic [55:0] cd0;
    logic [63:0] c, d, cd;
    logic [47:0] k;
    int total;
    for (int i = 0; i < 56; i++) cd0[6'(55 - i)] = key[6'(64 - PC1[i])];
    total = 0;
    for (int i = 0; i < n; i++) total += SHIFTS[i];
    c  = {36'b0, cd0[55:28]};
    d  = {36'b0, cd0[27:0]};
    c  = ((c << total) | (c >> (28 - total))) & 64'h0FFF_FFFF;
    d  = ((d << total) | (d >> (28 - total))) & 64'h0FFF_FFFF;
    cd = {8'b0, c[27:0], d[27:0]};
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return k;
  endfunction

  // DES round function f(R, K).
  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] er;
    logic [31:0] s, out;
    logic [5:0]  x;
    int idx;
    for (int i = 0; i < 48; i++) er[6'(47 - i)] = r[5'(32 - E[i])];
    er = er ^ k;
    s  = '0;
    for (int b = 0; b < 8; b++) begin
      x   = 6'(er >> (42 - 6 * b));
      idx = b * 64 + int'({x[5], x[0]}) * 16 + int'(x[4:1]);
      s   = {s[27:0], 4'(SBOX[idx])};
    end
    for (int i = 0; i < 32; i++) out[5'(31 - i)] = s[5'(32 - P[i])];
    return out;
  endfunction

  // Sixteen-round Feistel network fed with the DUT's subkey outputs.
  function automatic logic [63:0] feistel(input logic [63:0] blk);
    logic [63:0] v, res;
    logic [31:0] l, r, t;
    for (int i = 0; i < 64; i++) v[6'(63 - i)] = blk[6'(64 - IP[i])];
    l = v[63:32];
    r = v[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ des_f(r, sk[i]);
      l = t;
    end
    v = {r, l};
    for (int i = 0; i < 64; i++) res[6'(64 - IP[i])] = v[6'(63 - i)];
    return res;
  endfunction

  // Transaction-level model: a generation takes sixteen edges after the
  // accepted start; subkeys are only predicted when the set is complete.
  logic        m_busy  = 1'b0;
  logic        m_valid = 1'b0;
  logic        m_known = 1'b1;
  int          m_left  = 0;
  logic [63:0] m_key   = '0;
  logic        m_dec   = 1'b0;
  logic [47:0] exp_keys [16];

  initial for (int i = 0; i < 16; i++) exp_keys[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0; m_known = 1'b1; m_left = 0;
      for (int i = 0; i < 16; i++) exp_keys[i] = '0;
    end else if (!m_busy && start) begin
      m_busy = 1'b1; m_valid = 1'b0; m_known = 1'b0; m_left = 16;
      m_key = key_in; m_dec = decrypt;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_valid = 1'b1; m_known = 1'b1;
        for (int i = 0; i < 16; i++) exp_keys[i] = model_subkey(m_key, m_dec ? 16 - i : i + 1);
      end
    end
  end

  // Compare process: DUT versus model on every falling edge.
  always @(negedge clk) begin
    check("busy", {63'b0, busy}, {63'b0, m_busy});
    check("keys_valid", {63'b0, keys_valid}, {63'b0, m_valid});
    check("busy_and_valid", {63'b0, busy & keys_valid}, 64'd0);
    if (m_known)
      for (int i = 0; i < 16; i++) check($sformatf("subkey_%0d", i), {16'b0, sk[i]}, {16'b0, exp_keys[i]});
  end

  task automatic start_gen(input logic [63:0] key, input logic dec);
    @(negedge clk);
    key_in = key; decrypt = dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until keys_valid; optionally re-pulses start with a
  // zero key at a chosen edge. Bounded at 40 cycles.
  task automatic wait_valid(input int poke_at, output int cycles);
    cycles = 0;
    while (keys_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == poke_at) begin start = 1'b1; key_in = '0; end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  logic [63:0] ctxt;
  int lat;

  initial begin
    rst_n = 1'b0; start = 1'b0; key_in = '0; decrypt = 1'b0;
    check("model_k1",  {16'b0, model_subkey(KEY, 1)},  64'h1B02EFFC7072);
    check("model_k2",  {16'b0, model_subkey(KEY, 2)},  64'h79AED9DBC9E5);
    check("model_k16", {16'b0, model_subkey(KEY, 16)}, 64'hCB3D8B0E17F5);
    repeat (2) @(negedge clk);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_subkey_7", {16'b0, sk[7]}, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Encrypt schedule and latency.
    start_gen(KEY, 1'b0);
    wait_valid(-1, lat);
    check("enc_latency", 64'(lat), 64'd16);
    check("enc_subkey_0",  {16'b0, sk[0]},  64'h1B02EFFC7072);
    check("enc_subkey_1",  {16'b0, sk[1]},  64'h79AED9DBC9E5);
    check("enc_subkey_15", {16'b0, sk[15]}, 64'hCB3D8B0E17F5);
    ctxt = feistel(PTXT);
    check("des_encrypt", ctxt, CTXT);
    repeat (4) @(negedge clk);
    check("done_hold_valid", {63'b0, keys_valid}, 64'd1);

    // Decrypt order, restarted from DONE.
    start_gen(KEY, 1'b1);
    check("restart_valid_drop", {63'b0, keys_valid}, 64'd0);
    wait_valid(-1, lat);
    check("dec_latency", 64'(lat), 64'd16);
    check("dec_subkey_0",  {16'b0, sk[0]},  64'hCB3D8B0E17F5);
    check("dec_subkey_14", {16'b0, sk[14]}, 64'h79AED9DBC9E5);
    check("dec_subkey_15", {16'b0, sk[15]}, 64'h1B02EFFC7072);
    check("des_decrypt", feistel(ctxt), PTXT);

    // Start while busy (at r=5) with a zero key is ignored.
    start_gen(KEY, 1'b0);
    wait_valid(5, lat);
    check("busy_start_latency", 64'(lat), 64'd16);
    check("busy_start_subkey_0",  {16'b0, sk[0]},  64'h1B02EFFC7072);
    check("busy_start_subkey_15", {16'b0, sk[15]}, 64'hCB3D8B0E17F5);

    // Inputs changed after the start edge have no effect.
    start_gen(KEY, 1'b1);
    key_in = {$urandom, $urandom}; decrypt = 1'b0;
    wait_valid(-1, lat);
    check("stable_subkey_0", {16'b0, sk[0]}, 64'hCB3D8B0E17F5);

    // Restart from DONE with an all-zero key.
    start_gen(64'd0, 1'b0);
    check("zero_restart_valid", {63'b0, keys_valid}, 64'd0);
    wait_valid(-1, lat);
    check("zero_latency", 64'(lat), 64'd16);
    check("zero_subkey_0",  {16'b0, sk[0]},  64'd0);
    check("zero_subkey_15", {16'b0, sk[15]}, 64'd0);

    // Asynchronous reset mid-generation at r=7.
    start_gen(KEY, 1'b0);
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy",  {63'b0, busy}, 64'd0);
    check("async_rst_valid", {63'b0, keys_valid}, 64'd0);
    check("async_rst_subkey_0", {16'b0, sk[0]}, 64'd0);
    check("async_rst_subkey_6", {16'b0, sk[6]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", {62'b0, busy, keys_valid}, 64'd0);

    // Randomized start pulses, keys and direction.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 4) == 0);
      key_in  = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
